// File: rtl/dac_sample_gen.sv
// Rate-divided 16-bit phase accumulator mapped to one of four waveforms and
// offered to the SPI DAC serializer through a single valid/ready holding register.
module dac_sample_gen #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        wave_sel,
  input  logic [DATA_W-1:0] phase_inc,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  typedef enum logic [1:0] {
    WAVE_SAW = 2'b00,
    WAVE_TRI = 2'b01,
    WAVE_SQR = 2'b10,
    WAVE_MID = 2'b11
  } wave_e;

  logic [DATA_W-1:0] phase;
  logic [DATA_W-1:0] wave;
  logic [DIV_W-1:0]  div_cnt;
  logic              enable_d;
  logic              restart;
  logic              tick;
  logic              slot_free;

  assign restart   = enable & ~enable_d;
  // >= (not ==) so a rate_div lowered below the running count ticks at once
  assign tick      = enable & ~restart & (div_cnt >= rate_div);
  assign slot_free = ~sample_valid | sample_ready;

  always_comb begin
    wave = phase;
    case (wave_e'(wave_sel))
      WAVE_SAW: wave = phase;
      WAVE_TRI: wave = {phase[DATA_W-2:0], 1'b0} ^ {DATA_W{phase[DATA_W-1]}};
      WAVE_SQR: wave = {DATA_W{phase[DATA_W-1]}};
      WAVE_MID: wave = {1'b1, {(DATA_W-1){1'b0}}};
      default:  wave = phase;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      div_cnt      <= '0;
      enable_d     <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      enable_d <= enable;
      if (restart) begin
        phase        <= '0;
        div_cnt      <= '0;
        sample_valid <= 1'b0;
        overrun      <= 1'b0;
      end else begin
        if (enable) begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
        // a tick either reloads the holding register (covering a same-cycle
        // transfer) or drops its sample; otherwise a transfer empties it
        if (tick) begin
          phase <= phase + phase_inc;
          if (slot_free) begin
            sample_data  <= wave;
            sample_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (sample_valid && sample_ready) begin
          sample_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_gen.sv
// Self-checking bench for dac_sample_gen: directed scenarios plus randomized
// runs scored against a tick-count based reference model.
module tb_dac_sample_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  wave_sel;
  logic [15:0] phase_inc;
  logic [15:0] rate_div;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;

  int n_checks;
  int n_fail;

  // reference model: counts active cycles and ticks since the last restart
  bit          m_en_d;
  int unsigned m_n;
  int unsigned m_ticks;
  bit          m_valid;
  bit          m_ovr;
  logic [15:0] m_data;

  logic [15:0] got_d[$];
  int          got_t[$];

  dac_sample_gen #(.DATA_W(16), .DIV_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .wave_sel     (wave_sel),
    .phase_inc    (phase_inc),
    .rate_div     (rate_div),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_wave(input logic [1:0] sel, input int unsigned p);
    case (sel)
      2'd0:    return 16'(p);
      2'd1:    return (p < 32768) ? 16'(2 * p) : 16'(131071 - 2 * p);
      2'd2:    return (p >= 32768) ? 16'hFFFF : 16'h0000;
      default: return 16'h8000;
    endcase
  endfunction

  task automatic model_reset();
    m_en_d = 0; m_n = 0; m_ticks = 0; m_valid = 0; m_ovr = 0; m_data = 16'h0000;
  endtask

  // advance the model with the inputs present before the edge, then step the DUT
  task automatic cycle();
    bit tk;
    int unsigned period;
    tk = 0;
    period = int'(rate_div) + 1;
    if (enable && !m_en_d) begin
      m_n = 0; m_ticks = 0; m_valid = 0; m_ovr = 0;
    end else begin
      if (enable) begin
        tk = ((m_n % period) == period - 1);
        m_n++;
      end
      if (tk) begin
        if (!m_valid || sample_ready) begin
          m_data  = ref_wave(wave_sel, (m_ticks * int'(phase_inc)) % 65536);
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
        m_ticks++;
      end else if (m_valid && sample_ready) begin
        m_valid = 0;
      end
    end
    m_en_d = enable;
    @(posedge clk);
    #1;
  endtask

  task automatic run_collect(input int n);
    got_d.delete();
    got_t.delete();
    for (int i = 0; i < n; i++) begin
      cycle();
      if (sample_valid) begin
        got_d.push_back(sample_data);
        got_t.push_back(i);
      end
    end
  endtask

  task automatic restart_run(input logic [1:0] ws, input logic [15:0] inc,
                             input logic [15:0] rd, input logic rdy);
    enable = 0; wave_sel = ws; phase_inc = inc; rate_div = rd; sample_ready = rdy;
    cycle();
    enable = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", sample_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    n_checks++;
    if (sample_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h exp 0000", sample_data); end
    rst = 0;
  endtask

  task automatic test_saw_rate();
    logic [15:0] exp_d [4] = '{16'h0000, 16'h01BB, 16'h0376, 16'h0531};
    wave_sel = 2'd0; phase_inc = 16'd443; rate_div = 16'd3; sample_ready = 1; enable = 1;
    got_d.delete();
    got_t.delete();
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (sample_valid) begin got_d.push_back(sample_data); got_t.push_back(i); end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL saw_overrun cycle %0d: got %b exp 0", i, overrun); end
    end
    n_checks++;
    if (got_d.size() < 4) begin
      n_fail++; $display("FAIL saw_count: got %0d samples exp 4", got_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL saw_sample%0d: got %h exp %h", k, got_d[k], exp_d[k]); end
      end
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (got_t[k] - got_t[k-1] != 4) begin n_fail++; $display("FAIL saw_gap%0d: got %0d exp 4", k, got_t[k] - got_t[k-1]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_d [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000};
    restart_run(2'd0, 16'h8000, 16'd0, 1'b1);
    run_collect(6);
    n_checks++;
    if (got_d.size() < 4) begin
      n_fail++; $display("FAIL wrap_count: got %0d samples exp 4", got_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL wrap_sample%0d: got %h exp %h", k, got_d[k], exp_d[k]); end
        n_checks++;
        if (got_t[k] != got_t[0] + k) begin n_fail++; $display("FAIL wrap_timing%0d: got cycle %0d exp %0d", k, got_t[k], got_t[0] + k); end
      end
    end
  endtask

  task automatic test_tri_square();
    logic [15:0] exp_t [5] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic [15:0] exp_s [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    restart_run(2'd1, 16'h4000, 16'd0, 1'b1);
    run_collect(6);
    n_checks++;
    if (got_d.size() < 5) begin
      n_fail++; $display("FAIL tri_count: got %0d samples exp 5", got_d.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (got_d[k] !== exp_t[k]) begin n_fail++; $display("FAIL tri_sample%0d: got %h exp %h", k, got_d[k], exp_t[k]); end
      end
    end
    restart_run(2'd2, 16'h4000, 16'd0, 1'b1);
    run_collect(5);
    n_checks++;
    if (got_d.size() < 4) begin
      n_fail++; $display("FAIL sqr_count: got %0d samples exp 4", got_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_d[k] !== exp_s[k]) begin n_fail++; $display("FAIL sqr_sample%0d: got %h exp %h", k, got_d[k], exp_s[k]); end
      end
    end
  endtask

  task automatic test_overrun();
    int waited;
    restart_run(2'd0, 16'h1000, 16'd1, 1'b0);
    waited = 0;
    do begin cycle(); waited++; end while (!sample_valid && waited < 10);
    n_checks++;
    if (!sample_valid) begin n_fail++; $display("FAIL ovr_first_valid: got 0 exp 1 within 10 cycles"); end
    for (int j = 0; j < 6; j++) begin
      cycle();
      n_checks++;
      if (sample_valid !== 1'b1 || sample_data !== 16'h0000) begin
        n_fail++; $display("FAIL ovr_hold%0d: got valid %b data %h exp 1 0000", j, sample_valid, sample_data);
      end
      n_checks++;
      if (overrun !== (j >= 1)) begin n_fail++; $display("FAIL ovr_flag%0d: got %b exp %0d", j, overrun, j >= 1); end
    end
    sample_ready = 1;
    cycle();
    n_checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_drain: got valid %b overrun %b exp 0 1", sample_valid, overrun);
    end
    cycle();
    n_checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h4000) begin
      n_fail++; $display("FAIL ovr_advanced: got valid %b data %h exp 1 4000", sample_valid, sample_data);
    end
  endtask

  task automatic test_restart();
    int waited;
    sample_ready = 0;
    enable = 0;
    repeat (3) cycle();
    n_checks++;
    if (sample_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL rs_pending: got valid %b overrun %b exp 1 1", sample_valid, overrun);
    end
    rate_div = 16'd2;
    enable = 1;
    cycle();
    n_checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL rs_clear: got valid %b overrun %b exp 0 0", sample_valid, overrun);
    end
    sample_ready = 1;
    waited = 0;
    do begin cycle(); waited++; end while (!sample_valid && waited < 10);
    n_checks++;
    if (waited != 3) begin n_fail++; $display("FAIL rs_first_tick: got %0d cycles exp 3", waited); end
    n_checks++;
    if (sample_data !== 16'h0000) begin n_fail++; $display("FAIL rs_first_sample: got %h exp 0000", sample_data); end
  endtask

  task automatic test_async_reset();
    int waited;
    logic [15:0] exp_d [3] = '{16'h0000, 16'h04D2, 16'h09A4};
    restart_run(2'd3, 16'd1234, 16'd0, 1'b0);
    waited = 0;
    do begin cycle(); waited++; end while (!sample_valid && waited < 10);
    n_checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h8000) begin
      n_fail++; $display("FAIL ar_pre: got valid %b data %h exp 1 8000", sample_valid, sample_data);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (sample_valid !== 1'b0 || sample_data !== 16'h0000 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL ar_async: got valid %b data %h overrun %b exp 0 0000 0", sample_valid, sample_data, overrun);
    end
    enable = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    wave_sel = 2'd0; sample_ready = 1; enable = 1;
    run_collect(4);
    n_checks++;
    if (got_d.size() < 3) begin
      n_fail++; $display("FAIL ar_resume_count: got %0d samples exp 3", got_d.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL ar_resume%0d: got %h exp %h", k, got_d[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      restart_run(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 4)), 1'b1);
      for (int i = 0; i < 60; i++) begin
        wave_sel     = 2'($urandom_range(0, 3));
        sample_ready = ($urandom_range(0, 3) != 0);
        if (i > 0) enable = ($urandom_range(0, 15) != 0);
        cycle();
        n_checks++;
        if (sample_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid r%0d c%0d: got %b exp %b", r, i, sample_valid, m_valid); end
        n_checks++;
        if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_overrun r%0d c%0d: got %b exp %b", r, i, overrun, m_ovr); end
        if (m_valid) begin
          n_checks++;
          if (sample_data !== m_data) begin n_fail++; $display("FAIL rnd_data r%0d c%0d: got %h exp %h", r, i, sample_data, m_data); end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1; enable = 0; wave_sel = 2'd0; phase_inc = 16'd0; rate_div = 16'd0; sample_ready = 0;
    model_reset();
    test_reset();
    test_saw_rate();
    test_wrap();
    test_tri_square();
    test_overrun();
    test_restart();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
